truth_table_scanner: RTL and testbench
======================================

# truth_table_scanner

Sequential counterpart to the team's combinational sum-of-products blocks: instead of evaluating a function from its minterm list, it recovers the minterm list from a function. It steps all 2^N input combinations onto an external combinational function, samples the result, and reports a 2^N-bit minterm mask plus a minterm count. It sits in the bench/self-check layer of the guide exercises, next to SoP modules and their simplified forms.

## Interface
- N, default 4: number of function inputs; the legal range is 2..6.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  scan request; sampled only in IDLE.
- f  in  1  output of the function under scan; it must be a combinational function of vars.
- f_ref  in  1  output of the reference function; used only when the macro is defined.
- vars  out  N  current input combination; vars[N-1] is the MSB (x y w z ordering for N=4).
- mask  out  2^N  recovered minterms; mask[i] = f(i).
- count  out  N+1  number of minterms (popcount of mask).
- busy  out  1  high while a scan is in progress.
- done  out  1  one-cycle pulse when the scan completes.
- mismatch  out  1  sticky flag: f differed from f_ref at some index (tied 0 without the macro).
- first_diff  out  N  lowest index at which f differs from f_ref (tied 0 without the macro).

## Operation
- States:
  - IDLE → DRIVE on start=1.
  - DRIVE → SAMPLE, always.
  - SAMPLE → DRIVE while idx < 2^N-1.
  - SAMPLE → DONE when idx = 2^N-1.
  - DONE → IDLE, always.
- Accepting start in IDLE clears mask, count, mismatch and first_diff, and sets idx to 0.
- DRIVE: vars = idx is held stable for one full cycle so that f can settle.
- SAMPLE:
  - mask[idx] <= f; count <= count + f.
  - With the macro, if f ≠ f_ref and mismatch = 0, then mismatch <= 1 and first_diff <= idx.
  - idx increments, except at the last index.
- DONE: done = 1 and busy = 0; results hold.
- Results (mask, count, mismatch, first_diff) keep their values in IDLE until the next accepted start.
- start asserted in DRIVE, SAMPLE or DONE is ignored; it is not queued.
- vars in IDLE and DONE holds its last driven value; it is 0 after reset.
- count never wraps: N+1 bits covers 2^N when the function is constant 1.

## Timing
- Reset values: state = IDLE, vars = 0, mask = 0, count = 0, busy = 0, done = 0, mismatch = 0, first_diff = 0.
- Let edge E be the edge that samples start = 1 in IDLE. busy rises after E and stays high through the last SAMPLE.
- Each combination takes 2 cycles: DRIVE, then SAMPLE.
- done is high during the cycle following edge E + 2·2^N; for N = 4 this is 32 cycles after E.
- The earliest next accepted start is at the edge after done; back-to-back scans therefore have a 1-cycle IDLE gap.
- Reset asserted mid-scan returns the block to IDLE and all reset values immediately, with no clock needed. No partial results survive.

## Configuration
- EQUIV_CHECK_EN, when defined:
  - f_ref is compared against f in every SAMPLE.
  - mismatch and first_diff are driven as described in Operation.
- When undefined:
  - f_ref is ignored.
  - mismatch and first_diff are constant 0.
  - No comparison logic is built.
  - The port list is unchanged.

## Structure
- Shared package/include holds:
  - state encodings: IDLE = 0, DRIVE = 1, SAMPLE = 2, DONE = 3;
  - the default N;
  - the MINTERMS = 2^N width constant.
- One sub-module, scan_counter: a loadable N-bit index counter with clear, enable and a terminal-count output (idx = 2^N-1). The FSM consumes its terminal count.

## Test plan
- N = 4, f = SoP(0,1,3,5,8,9,13), one start → mask = 16'h232B, count = 7, done exactly 32 cycles after the accepting edge.
- Same f with f_ref = simplified form w'z + y'w'z' + x'y'z, macro on → mismatch = 0, first_diff = 0.
- f_ref with minterm 3 removed, macro on → mismatch = 1, first_diff = 3, and mask still 16'h232B.
- Constant f = 0 → mask = 0, count = 0. Constant f = 1 → mask = 16'hFFFF, count = 16.
- start pulsed again at cycle 5 of a scan → ignored, done still at cycle 32; a new start after done → results cleared, then the rescan reproduces the same mask.
- reset asserted asynchronously at cycle 10 of a scan → all outputs 0 at once; after release, a fresh start gives the full correct mask.

Source files
------------

// File: rtl/truth_table_scanner_pkg.sv
// truth_table_scanner_pkg
// Shared definitions for the truth-table scanner: FSM state encoding, the
// default number of function inputs and the minterm-mask width constant.
package truth_table_scanner_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StDrive  = 2'd1,
        StSample = 2'd2,
        StDone   = 2'd3
    } state_e;

    // Default number of scanned function inputs (legal range 2..6).
    localparam int unsigned DefaultN = 4;

    // Width of the minterm mask for the default input count.
    localparam int unsigned MINTERMS = 2 ** DefaultN;

    // Minterm-mask width for an arbitrary input count.
    function automatic int unsigned minterms_of(input int unsigned n);
        return 2 ** n;
    endfunction

endpackage

// File: rtl/truth_table_scanner_scan_counter.sv
// truth_table_scanner_scan_counter
// Loadable N-bit index counter used to step through all input combinations.
// Ports:
//   clk, reset  rising-edge clock, asynchronous active-high reset
//   clear       synchronous clear to 0 (highest priority after reset)
//   load        synchronous load of load_value
//   load_value  value taken on load
//   en          advance by one; holds once the terminal count is reached
//   idx         current index
//   tc          terminal count, high when idx = 2^N-1
module truth_table_scanner_scan_counter
    import truth_table_scanner_pkg::*;
#(
    parameter int unsigned N = DefaultN
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         load,
    input  logic [N-1:0] load_value,
    input  logic         en,
    output logic [N-1:0] idx,
    output logic         tc
);

    assign tc = &idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx <= '0;
        end else if (clear) begin
            idx <= '0;
        end else if (load) begin
            idx <= load_value;
        end else if (en && !tc) begin
            // Saturate at the last index so vars keeps showing it afterwards.
            idx <= idx + N'(1);
        end
    end

endmodule

// File: rtl/truth_table_scanner.sv
// truth_table_scanner
// Recovers the minterm list of an external combinational function by stepping
// all 2^N input combinations onto it (two cycles each: DRIVE then SAMPLE) and
// collecting the sampled outputs into a mask plus a minterm count.
// Optional feature macro: EQUIV_CHECK_EN -- when defined, f is compared with
// f_ref on every sample and the first differing index is recorded; when not
// defined, f_ref is ignored and mismatch/first_diff are tied to 0.
// Ports:
//   clk, reset  rising-edge clock, asynchronous active-high reset
//   start       scan request, sampled only in IDLE
//   f           output of the function under scan (combinational in vars)
//   f_ref       reference function output (EQUIV_CHECK_EN only)
//   vars        current input combination, vars[N-1] is the MSB
//   mask        recovered minterms, mask[i] = f(i)
//   count       number of minterms in mask
//   busy        high while a scan is in progress
//   done        one-cycle pulse on scan completion
//   mismatch    sticky: f differed from f_ref at some index
//   first_diff  lowest index at which f differed from f_ref
module truth_table_scanner
    import truth_table_scanner_pkg::*;
#(
    parameter int unsigned N = DefaultN
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              f,
    input  logic              f_ref,
    output logic [N-1:0]      vars,
    output logic [2**N-1:0]   mask,
    output logic [N:0]        count,
    output logic              busy,
    output logic              done,
    output logic              mismatch,
    output logic [N-1:0]      first_diff
);

    state_e         state_q;
    logic [N-1:0]   idx;
    logic           tc;
    logic           accept;
    logic           sample_en;

    assign accept    = (state_q == StIdle) && start;
    assign sample_en = (state_q == StSample);

    truth_table_scanner_scan_counter #(
        .N (N)
    ) u_scan_counter (
        .clk        (clk),
        .reset      (reset),
        .clear      (accept),
        .load       (1'b0),
        .load_value ('0),
        .en         (sample_en),
        .idx        (idx),
        .tc         (tc)
    );

    // The index register drives the function inputs directly; it is only
    // updated at the end of SAMPLE, so it is stable across DRIVE and SAMPLE.
    assign vars = idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            mask    <= '0;
            count   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StDrive;
                        mask    <= '0;
                        count   <= '0;
                        busy    <= 1'b1;
                    end
                end
                StDrive: begin
                    state_q <= StSample;
                end
                StSample: begin
                    mask[idx] <= f;
                    count     <= count + {{N{1'b0}}, f};
                    if (tc) begin
                        state_q <= StDone;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        state_q <= StDrive;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

`ifdef EQUIV_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mismatch   <= 1'b0;
            first_diff <= '0;
        end else if (accept) begin
            mismatch   <= 1'b0;
            first_diff <= '0;
        end else if (sample_en && (f != f_ref) && !mismatch) begin
            // Only the first difference is recorded; later ones are ignored.
            mismatch   <= 1'b1;
            first_diff <= idx;
        end
    end
`else
    logic unused_f_ref;
    assign unused_f_ref = f_ref;
    assign mismatch     = 1'b0;
    assign first_diff   = '0;
`endif

endmodule

// File: tb/tb_truth_table_scanner.sv
// tb_truth_table_scanner
// Directed bench for truth_table_scanner (N = 4). The function under scan is
// a lookup table indexed by vars. A timeline model predicts every output on
// every cycle from the scan position; literal checks pin the headline results.
module tb_truth_table_scanner;

    localparam int unsigned N = 4;

`ifdef EQUIV_CHECK_EN
    localparam bit EqOn = 1'b1;
`else
    localparam bit EqOn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        f;
    logic        f_ref;
    logic [3:0]  vars;
    logic [15:0] mask;
    logic [4:0]  count;
    logic        busy;
    logic        done;
    logic        mismatch;
    logic [3:0]  first_diff;

    logic [15:0] f_table = 16'h0000;
    logic [15:0] f_ref_table = 16'h0000;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;
    int cyc = 0;

    assign f     = f_table[vars];
    assign f_ref = f_ref_table[vars];

    always #5 clk = ~clk;

    truth_table_scanner #(
        .N (N)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .f          (f),
        .f_ref      (f_ref),
        .vars       (vars),
        .mask       (mask),
        .count      (count),
        .busy       (busy),
        .done       (done),
        .mismatch   (mismatch),
        .first_diff (first_diff)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Model: m_k is the cycle number after the accepting edge (1 = first cycle).
    bit          m_active = 1'b0;
    int          m_k = 0;
    int          m_held = 0;
    logic [3:0]  m_idle_vars = 4'd0;
    logic [15:0] m_f = 16'h0000;
    logic [15:0] m_r = 16'h0000;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_active    <= 1'b0;
            m_k         <= 0;
            m_held      <= 0;
            m_idle_vars <= 4'd0;
        end else if (!m_active) begin
            if (start) begin
                m_active <= 1'b1;
                m_k      <= 1;
                m_f      <= f_table;
                m_r      <= f_ref_table;
            end
        end else if (m_k == 33) begin
            m_active    <= 1'b0;
            m_held      <= 16;
            m_idle_vars <= 4'd15;
        end else begin
            m_k <= m_k + 1;
        end
    end

    function automatic int lowest_set(input logic [15:0] v);
        for (int i = 0; i < 16; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    task automatic compare_model();
        int          s;
        logic [31:0] lm;
        logic [15:0] exp_mask;
        logic [15:0] diff;
        bit          exp_mm;
        int          exp_fd;
        int          exp_vars;
        if (m_active) begin
            s = (m_k - 1) / 2;
            if (s > 16) s = 16;
            exp_vars = (m_k <= 32) ? (m_k - 1) / 2 : 15;
        end else begin
            s = m_held;
            exp_vars = int'(m_idle_vars);
        end
        lm       = (s >= 16) ? 32'h0000_FFFF : ((32'd1 << s) - 32'd1);
        exp_mask = m_f & lm[15:0];
        diff     = (m_f ^ m_r) & lm[15:0];
        exp_mm   = EqOn && (diff != 16'h0000);
        exp_fd   = exp_mm ? lowest_set(diff) : 0;
        check("model_busy", int'(busy), int'(m_active && m_k <= 32));
        check("model_done", int'(done), int'(m_active && m_k == 33));
        check("model_vars", int'(vars), exp_vars);
        check("model_mask", int'(mask), int'(exp_mask));
        check("model_count", int'(count), $countones(exp_mask));
        check("model_mismatch", int'(mismatch), int'(exp_mm));
        check("model_first_diff", int'(first_diff), exp_fd);
    endtask

    task automatic tick();
        @(negedge clk);
        if (chk_en) compare_model();
    endtask

    // Accepts a scan, optionally re-pulses start at restart_at cycles into it,
    // waits (bounded) for done and checks its latency, then steps into IDLE.
    task automatic run_scan(input logic [15:0] ft, input logic [15:0] rt,
                            input int restart_at);
        int ce;
        int lat;
        f_table     = ft;
        f_ref_table = rt;
        start = 1'b1;
        tick();
        start = 1'b0;
        ce = cyc;
        check("start_clears_mask", int'(mask), 0);
        check("start_clears_count", int'(count), 0);
        check("busy_after_start", int'(busy), 1);
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            if (i == restart_at) start = 1'b1;
            tick();
            start = 1'b0;
            if (done) begin
                lat = cyc - ce;
                break;
            end
        end
        check("done_latency", lat, 32);
        tick();
    endtask

    function automatic logic [15:0] simplified_ref();
        logic [15:0] t;
        logic [3:0]  b;
        for (int i = 0; i < 16; i++) begin
            b = 4'(i);
            // x=b[3] y=b[2] w=b[1] z=b[0]: w'z + y'w'z' + x'y'z
            t[i] = (!b[1] && b[0]) || (!b[2] && !b[1] && !b[0]) || (!b[3] && !b[2] && b[0]);
        end
        return t;
    endfunction

    initial begin
        logic [15:0] sop;
        int          ce;
        sop = simplified_ref();

        #1 reset = 1'b1;
        repeat (3) tick();
        #2 reset = 1'b0;
        chk_en = 1'b1;
        tick();
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_mask", int'(mask), 0);
        check("reset_count", int'(count), 0);
        check("reset_vars", int'(vars), 0);

        // SoP(0,1,3,5,8,9,13) against its simplified form.
        run_scan(16'h232B, sop, -1);
        check("sop_mask", int'(mask), 32'h232B);
        check("sop_count", int'(count), 7);
        check("sop_mismatch", int'(mismatch), 0);
        check("sop_first_diff", int'(first_diff), 0);
        check("idle_vars_hold", int'(vars), 15);

        // Reference with minterm 3 removed.
        run_scan(16'h232B, 16'h2323, -1);
        check("diff_mask", int'(mask), 32'h232B);
        check("diff_mismatch", int'(mismatch), EqOn ? 1 : 0);
        check("diff_first_diff", int'(first_diff), EqOn ? 3 : 0);

        run_scan(16'h0000, 16'h0000, -1);
        check("zero_mask", int'(mask), 0);
        check("zero_count", int'(count), 0);

        run_scan(16'hFFFF, 16'hFFFF, -1);
        check("ones_mask", int'(mask), 32'hFFFF);
        check("ones_count", int'(count), 16);

        // Stray start mid-scan is ignored; rescan afterwards reproduces the mask.
        run_scan(16'h232B, 16'h232B, 4);
        check("restart_mask", int'(mask), 32'h232B);
        run_scan(16'h232B, 16'h232B, -1);
        check("rescan_mask", int'(mask), 32'h232B);
        check("rescan_count", int'(count), 7);

        // Asynchronous reset mid-scan.
        f_table     = 16'h232B;
        f_ref_table = 16'h2323;
        start = 1'b1;
        tick();
        start = 1'b0;
        ce = cyc;
        repeat (9) tick();
        check("pre_reset_busy", int'(busy), 1);
        #2 reset = 1'b1;
        #1;
        check("async_busy", int'(busy), 0);
        check("async_done", int'(done), 0);
        check("async_vars", int'(vars), 0);
        check("async_mask", int'(mask), 0);
        check("async_count", int'(count), 0);
        check("async_mismatch", int'(mismatch), 0);
        check("async_first_diff", int'(first_diff), 0);
        check("async_reset_cycle", cyc - ce, 9);
        repeat (2) tick();
        #2 reset = 1'b0;
        tick();
        run_scan(16'h232B, sop, -1);
        check("post_reset_mask", int'(mask), 32'h232B);
        check("post_reset_count", int'(count), 7);

        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
